pc_ctrl: RTL and testbench

PC_CTRL -- requirements
Module: pc_ctrl

---
 rtl/pc_ctrl.sv | 96 +++++++++
 tb/tb_pc_ctrl.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/pc_ctrl.sv
// Fetch PC sequencer with delayed-redirect capture for the branch delay slot.
// Define PC_CTRL_EXC_EN to enable exc_req/eret_req/epc handling and f_adel.
module pc_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_4180,
  parameter logic [31:0] IMEM_LO    = 32'h0000_3000,
  parameter logic [31:0] IMEM_HI    = 32'h0000_6FFC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        imem_ready,
  input  logic        d_redirect,
  input  logic [31:0] d_target,
  input  logic        exc_req,
  input  logic        eret_req,
  input  logic [31:0] epc,
  output logic [31:0] f_pc,
  output logic [31:0] npc,
  output logic        f_adel,
  output logic        pend_valid
);

  logic [31:0] r_f_pc;
  logic        r_pend_valid;
  logic [31:0] r_pend_tgt;

  logic        w_adv;
  logic        w_acc;
  logic        w_exc;
  logic        w_eret;
  logic [31:0] w_epc;
  logic [31:0] w_npc;

  assign w_adv = ~stall & imem_ready;
  assign w_acc = d_redirect & ~stall;

`ifdef PC_CTRL_EXC_EN
  assign w_exc  = exc_req;
  assign w_eret = eret_req;
  assign w_epc  = epc;
  assign f_adel = (r_f_pc[1:0] != 2'b00)
                | (r_f_pc < IMEM_LO)
                | (r_f_pc > IMEM_HI);
`else
  logic w_unused;
  assign w_unused = ^{exc_req, eret_req, epc};
  assign w_exc  = 1'b0;
  assign w_eret = 1'b0;
  assign w_epc  = 32'h0;
  assign f_adel = 1'b0;
`endif

  // Delay slot: a redirect only lands once the slot fetch completes.
  always_comb begin
    w_npc = r_f_pc;
    if (reset)
      w_npc = RESET_PC;
    else if (w_exc)
      w_npc = EXC_VECTOR;
    else if (w_eret)
      w_npc = w_epc;
    else if (w_adv) begin
      if (r_pend_valid)
        w_npc = r_pend_tgt;
      else if (w_acc)
        w_npc = d_target;
      else
        w_npc = r_f_pc + 32'd4;
    end
  end

  always_ff @(posedge clk) begin
    r_f_pc <= w_npc;
  end

  // First captured target wins until it is consumed.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pend_valid <= 1'b0;
      r_pend_tgt   <= 32'h0;
    end else if (w_exc | w_eret) begin
      r_pend_valid <= 1'b0;
    end else if (w_adv & r_pend_valid) begin
      r_pend_valid <= 1'b0;
    end else if (w_acc & ~imem_ready & ~r_pend_valid) begin
      r_pend_valid <= 1'b1;
      r_pend_tgt   <= d_target;
    end
  end

  assign f_pc       = r_f_pc;
  assign npc        = w_npc;
  assign pend_valid = r_pend_valid;

endmodule

// File: tb/tb_pc_ctrl.sv
// Scoreboard bench for pc_ctrl; expected PC state is queued per drive.
// Expectations follow PC_CTRL_EXC_EN when the bench is built with it.
module tb_pc_ctrl;

`ifdef PC_CTRL_EXC_EN
  localparam bit EXC = 1'b1;
`else
  localparam bit EXC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        imem_ready;
  logic        d_redirect;
  logic [31:0] d_target;
  logic        exc_req;
  logic        eret_req;
  logic [31:0] epc;
  logic [31:0] f_pc;
  logic [31:0] npc;
  logic        f_adel;
  logic        pend_valid;

  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic        pv;
  } exp_t;

  exp_t q[$];
  int n_chk = 0;
  int n_err = 0;

  pc_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .imem_ready (imem_ready),
    .d_redirect (d_redirect),
    .d_target   (d_target),
    .exc_req    (exc_req),
    .eret_req   (eret_req),
    .epc        (epc),
    .f_pc       (f_pc),
    .npc        (npc),
    .f_adel     (f_adel),
    .pend_valid (pend_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic adel_of(input logic [31:0] pc);
    return EXC & ((pc[1:0] != 2'b00) ||
                  (pc < 32'h0000_3000) ||
                  (pc > 32'h0000_6FFC));
  endfunction

  task automatic step(input string       tag,
                      input logic        rst,
                      input logic        st,
                      input logic        rdy,
                      input logic        rd,
                      input logic [31:0] tgt,
                      input logic        ex,
                      input logic        er,
                      input logic [31:0] ep,
                      input logic [31:0] e_pc,
                      input logic        e_pv);
    exp_t e;
    reset      = rst;
    stall      = st;
    imem_ready = rdy;
    d_redirect = rd;
    d_target   = tgt;
    exc_req    = ex;
    eret_req   = er;
    epc        = ep;
    q.push_back('{tag, e_pc, e_pv});
    #1;
    chk({tag, ".npc"}, npc, e_pc);
    @(posedge clk);
    #1;
    e = q.pop_front();
    chk({e.tag, ".pc"}, f_pc, e.pc);
    chk({e.tag, ".pv"}, {31'h0, pend_valid}, {31'h0, e.pv});
    chk({e.tag, ".adel"}, {31'h0, f_adel}, {31'h0, adel_of(e.pc)});
    @(negedge clk);
  endtask

  logic [31:0] p9;
  logic [31:0] p10;

  initial begin
    @(negedge clk);
    step("rst0", 1, 0, 1, 1, 32'h5000, 1, 0, 0, 32'h3000, 0);
    step("rst1", 1, 0, 1, 0, 32'h0, 0, 1, 32'h5000, 32'h3000, 0);
    step("seq0", 0, 0, 1, 0, 32'h0, 0, 0, 0, 32'h3004, 0);
    step("seq1", 0, 0, 1, 0, 32'h0, 0, 0, 0, 32'h3008, 0);
    step("seq2", 0, 0, 1, 0, 32'h0, 0, 0, 0, 32'h300C, 0);
    step("seq3", 0, 0, 1, 0, 32'h0, 0, 0, 0, 32'h3010, 0);
    step("redir", 0, 0, 1, 1, 32'h3100, 0, 0, 0, 32'h3100, 0);
    step("wait0", 0, 0, 0, 1, 32'h3200, 0, 0, 0, 32'h3100, 1);
    step("wait1", 0, 0, 0, 1, 32'h3300, 0, 0, 0, 32'h3100, 1);
    step("wait2", 0, 0, 0, 1, 32'h3300, 0, 0, 0, 32'h3100, 1);
    step("pend", 0, 0, 1, 0, 32'h0, 0, 0, 0, 32'h3200, 0);
    step("stl0", 0, 1, 1, 1, 32'h3400, 0, 0, 0, 32'h3200, 0);
    step("stl1", 0, 1, 1, 1, 32'h3400, 0, 0, 0, 32'h3200, 0);
    step("stl2", 0, 0, 1, 1, 32'h3400, 0, 0, 0, 32'h3400, 0);
    step("nrdy", 0, 0, 0, 0, 32'h0, 0, 0, 0, 32'h3400, 0);
    step("stlh", 0, 1, 1, 0, 32'h0, 0, 0, 0, 32'h3400, 0);
    step("mis0", 0, 0, 1, 1, 32'h3102, 0, 0, 0, 32'h3102, 0);
    step("mis1", 0, 0, 1, 0, 32'h0, 0, 0, 0, 32'h3106, 0);
    step("hi0", 0, 0, 1, 1, 32'h7000, 0, 0, 0, 32'h7000, 0);
    step("hi1", 0, 0, 1, 1, 32'h6FFC, 0, 0, 0, 32'h6FFC, 0);
    step("hi2", 0, 0, 1, 0, 32'h0, 0, 0, 0, 32'h7000, 0);
    step("lo0", 0, 0, 1, 1, 32'h2FFC, 0, 0, 0, 32'h2FFC, 0);
    step("lo1", 0, 0, 1, 0, 32'h0, 0, 0, 0, 32'h3000, 0);
    step("wr0", 0, 0, 1, 1, 32'hFFFF_FFFC, 0, 0, 0,
         32'hFFFF_FFFC, 0);
    step("wr1", 0, 0, 1, 0, 32'h0, 0, 0, 0, 32'h0, 0);
    step("exs0", 0, 0, 1, 1, 32'h3000, 0, 0, 0, 32'h3000, 0);
    step("exs1", 0, 0, 0, 1, 32'h3500, 0, 0, 0, 32'h3000, 1);
    step("exc", 0, 1, 1, 0, 32'h0, 1, 0, 0,
         EXC ? 32'h4180 : 32'h3000, !EXC);
    step("eret", 0, 1, 1, 0, 32'h0, 0, 1, 32'h3020,
         EXC ? 32'h3020 : 32'h3000, !EXC);
    p9 = EXC ? 32'h3024 : 32'h3500;
    step("post", 0, 0, 1, 0, 32'h0, 0, 0, 0, p9, 0);
    p10 = EXC ? 32'h4180 : p9 + 32'd4;
    step("exprio", 0, 0, 1, 0, 32'h0, 1, 1, 32'h5000, p10, 0);
    step("erprio", 0, 0, 1, 1, 32'h3600, 0, 1, 32'h3040,
         EXC ? 32'h3040 : 32'h3600, 0);
    step("rw0", 0, 0, 0, 1, 32'h3700, 0, 0, 0,
         EXC ? 32'h3040 : 32'h3600, 1);
    step("rw1", 1, 0, 0, 0, 32'h0, 0, 0, 0, 32'h3000, 0);
    step("rw2", 0, 0, 1, 0, 32'h0, 0, 0, 0, 32'h3004, 0);
    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
